bp_me_nonsynth_cce_mem_stub: RTL and testbench

Simulation-only memory model that sits directly downstream of the CCE memory command port. It consumes CCE mem_cmd messages and returns mem_resp messages after a programmable latency, using a small block-granular backing store. Together with the CCE tracer it gives the ME testbench a closed command/response loop with deterministic timing. It handles one transaction at a time.

---
 rtl/bp_me_nonsynth_cce_mem_stub_pkg.sv | 47 ++++
 rtl/bp_me_nonsynth_mem_stub_byte_merge.sv | 29 ++
 rtl/bp_me_nonsynth_cce_mem_stub.sv | 104 ++++++++++
 tb/tb_bp_me_nonsynth_cce_mem_stub.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_nonsynth_cce_mem_stub_pkg.sv
// rtl/bp_me_nonsynth_cce_mem_stub_pkg.sv - CCE memory message types and geometry for the mem stub
package bp_me_nonsynth_cce_mem_stub_pkg;

    localparam int paddr_width_p      = 40;
    localparam int cce_block_width_p  = 512;
    localparam int lce_id_width_p     = 4;
    localparam int lce_assoc_p        = 8;
    localparam int way_id_width_lp    = $clog2(lce_assoc_p);
    localparam int block_bytes_lp     = cce_block_width_p / 8;
    localparam int lg_block_bytes_lp  = $clog2(block_bytes_lp);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3
    } bp_cce_mem_cmd_type_e;

    // Transfer size is 2^size bytes.
    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]  lce_id;
        logic [way_id_width_lp-1:0] way_id;
        logic [2:0]                 state;
        logic                       speculative;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_cce_mem_payload_s          payload;
        bp_mem_size_e                 size;
        logic [paddr_width_p-1:0]     addr;
        bp_cce_mem_cmd_type_e         msg_type;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bp_me_nonsynth_mem_stub_byte_merge.sv
// rtl/bp_me_nonsynth_mem_stub_byte_merge.sv - byte-granular merge and extract for uncached accesses
module bp_me_nonsynth_mem_stub_byte_merge
    import bp_me_nonsynth_cce_mem_stub_pkg::*;
(
    input  logic [cce_block_width_p-1:0] block,
    input  logic [cce_block_width_p-1:0] data,
    input  logic [lg_block_bytes_lp-1:0] offset,
    input  logic [2:0]                   size,
    output logic [cce_block_width_p-1:0] merged,
    output logic [cce_block_width_p-1:0] extracted
);
    int nbytes;
    int aligned;

    always_comb begin
        nbytes    = 1 << size;
        aligned   = int'(offset) & ~(nbytes - 1);
        merged    = block;
        extracted = '0;
        for (int i = 0; i < block_bytes_lp; i++) begin
            // Bytes that would land past the end of the block simply never match.
            if (i >= aligned && (i - aligned) < nbytes)
                merged[8*i +: 8] = data[8*(i - aligned) +: 8];
            if (i < nbytes && (aligned + i) < block_bytes_lp)
                extracted[8*i +: 8] = block[8*(aligned + i) +: 8];
        end
    end

endmodule

// File: rtl/bp_me_nonsynth_cce_mem_stub.sv
// rtl/bp_me_nonsynth_cce_mem_stub.sv - single-transaction CCE memory model with programmable latency
module bp_me_nonsynth_cce_mem_stub
    import bp_me_nonsynth_cce_mem_stub_pkg::*;
#(
    parameter int mem_els_p     = 256,
    parameter int mem_latency_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);
    localparam int lg_mem_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int cnt_width_lp  = (mem_latency_p > 0) ? $clog2(mem_latency_p + 1) : 1;

    typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;

    state_e                       state;
    logic [cnt_width_lp-1:0]      cnt;
    logic [cce_block_width_p-1:0] store [mem_els_p];
    bp_cce_mem_msg_s              cmd;
    bp_cce_mem_msg_s              resp;
    bp_cce_mem_msg_s              resp_next;
    logic                         resp_v;
    logic [lg_mem_els_lp-1:0]     idx;
    logic [cce_block_width_p-1:0] block;
    logic [cce_block_width_p-1:0] merged;
    logic [cce_block_width_p-1:0] extracted;
    logic                         accept;

    assign cmd   = bp_cce_mem_msg_s'(mem_cmd_i);
    assign idx   = cmd.addr[lg_block_bytes_lp +: lg_mem_els_lp];
    assign block = store[idx];

    bp_me_nonsynth_mem_stub_byte_merge byte_merge (
        .block     (block),
        .data      (cmd.data),
        .offset    (cmd.addr[lg_block_bytes_lp-1:0]),
        .size      (cmd.size),
        .merged    (merged),
        .extracted (extracted)
    );

    // Read data is captured at acceptance, so later writes cannot disturb it.
    always_comb begin
        resp_next = cmd;
        case (cmd.msg_type)
            e_cce_mem_rd:    resp_next.data = block;
            e_cce_mem_uc_rd: resp_next.data = extracted;
            default:         resp_next.data = '0;
        endcase
    end

    assign mem_cmd_ready_o = (state == e_idle) && !reset_i;
    assign accept          = mem_cmd_v_i && mem_cmd_ready_o;
    assign mem_resp_o      = resp;
    assign mem_resp_v_o    = resp_v;

    // WAIT always absorbs one cycle, so valid rises 1+mem_latency_p edges after acceptance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= e_idle;
            cnt    <= '0;
            resp   <= '0;
            resp_v <= 1'b0;
            for (int i = 0; i < mem_els_p; i++)
                store[i] <= '0;
        end else begin
            case (state)
                e_idle: if (accept) begin
                    resp  <= resp_next;
                    cnt   <= cnt_width_lp'(mem_latency_p);
                    state <= e_wait;
                    if (cmd.msg_type == e_cce_mem_wr)
                        store[idx] <= cmd.data;
                    else if (cmd.msg_type == e_cce_mem_uc_wr)
                        store[idx] <= merged;
                end
                e_wait: begin
                    if (cnt == '0) begin
                        state  <= e_resp;
                        resp_v <= 1'b1;
                    end else begin
                        cnt <= cnt - cnt_width_lp'(1);
                    end
                end
                e_resp: if (mem_resp_yumi_i) begin
                    state  <= e_idle;
                    resp_v <= 1'b0;
                end
                default: state <= e_idle;
            endcase
        end
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_yumi_i |-> mem_resp_v_o)
        else $error("mem_resp_yumi_i asserted while mem_resp_v_o is low");

endmodule

// File: tb/tb_bp_me_nonsynth_cce_mem_stub.sv
// tb/tb_bp_me_nonsynth_cce_mem_stub.sv - scoreboard bench for the CCE mem stub at latency 4 and 0
module tb_bp_me_nonsynth_cce_mem_stub;
    import bp_me_nonsynth_cce_mem_stub_pkg::*;

    typedef logic [cce_block_width_p-1:0] blk_t;
    typedef struct {
        int                       d;
        bp_cce_mem_cmd_type_e     t;
        logic [paddr_width_p-1:0] addr;
        bp_mem_size_e             sz;
        blk_t                     data;
        blk_t                     exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [cce_mem_msg_width_lp-1:0] cmd  [2];
    logic [cce_mem_msg_width_lp-1:0] resp [2];
    logic cmd_v [2];
    logic ready [2];
    logic resp_v[2];
    logic yumi  [2];

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;
    int acc     = 0;
    bp_cce_mem_msg_s sb[$];
    vec_t vecs[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_me_nonsynth_cce_mem_stub #(.mem_els_p(256), .mem_latency_p(4)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .mem_cmd_i(cmd[0]), .mem_cmd_v_i(cmd_v[0]), .mem_cmd_ready_o(ready[0]),
        .mem_resp_o(resp[0]), .mem_resp_v_o(resp_v[0]), .mem_resp_yumi_i(yumi[0])
    );

    bp_me_nonsynth_cce_mem_stub #(.mem_els_p(256), .mem_latency_p(0)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .mem_cmd_i(cmd[1]), .mem_cmd_v_i(cmd_v[1]), .mem_cmd_ready_o(ready[1]),
        .mem_resp_o(resp[1]), .mem_resp_v_o(resp_v[1]), .mem_resp_yumi_i(yumi[1])
    );

    function automatic void chk(string nm, logic [639:0] act, logic [639:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bp_cce_mem_msg_s mk(bp_cce_mem_cmd_type_e t, logic [paddr_width_p-1:0] addr,
                                           bp_mem_size_e sz, blk_t data);
        bp_cce_mem_msg_s m;
        m.msg_type            = t;
        m.addr                = addr;
        m.size                = sz;
        m.payload.lce_id      = 4'd1;
        m.payload.way_id      = 3'd3;
        m.payload.state       = 3'd2;
        m.payload.speculative = 1'b0;
        m.data                = data;
        return m;
    endfunction

    task automatic send(input int d, input bp_cce_mem_msg_s m, input blk_t exp_data, output bit ok);
        bp_cce_mem_msg_s e;
        e = m;
        e.data = exp_data;
        sb.push_back(e);
        ok = 1'b0;
        @(negedge clk);
        cmd[d]   = m;
        cmd_v[d] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ready[d]) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cmd_v[d] = 1'b0;
        if (!ok) begin
            nchecks++;
            nfail++;
            $display("FAIL accept_timeout: dut%0d never raised ready, expected ready within 20 cycles", d);
            void'(sb.pop_back());
        end
    endtask

    task automatic wait_resp(input int d, input int lat_exp, input int hold, input bit jam);
        bit seen = 1'b0;
        bit stable = 1'b1;
        bp_cce_mem_msg_s e;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = resp_v[d];
        end
        e = sb.pop_front();
        if (!seen) begin
            nchecks++;
            nfail++;
            $display("FAIL resp_timeout: dut%0d valid stayed 0, expected 1 within 40 cycles", d);
            return;
        end
        chk("latency", 640'(cyc - acc), 640'(lat_exp));
        chk("resp_msg", 640'(resp[d]), 640'(e));
        for (int h = 0; h < hold; h++) begin
            if (jam) begin
                cmd[d]   = mk(e_cce_mem_wr, 40'h80, e_mem_size_64, '0);
                cmd_v[d] = 1'b1;
            end
            @(posedge clk);
            #1;
            stable &= resp_v[d] && (resp[d] === e) && !ready[d];
        end
        if (hold > 0) chk("hold_stable", 640'(stable), 640'(1));
        yumi[d] = 1'b1;
        @(posedge clk);
        #1;
        yumi[d]  = 1'b0;
        cmd_v[d] = 1'b0;
        chk("valid_drop", 640'(resp_v[d]), 640'(0));
        chk("ready_back", 640'(ready[d]), 640'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;
        bp_cce_mem_msg_s e;
        for (int d = 0; d < 2; d++) begin
            cmd[d]   = '0;
            cmd_v[d] = 1'b0;
            yumi[d]  = 1'b0;
        end

        vecs[0]  = '{0, e_cce_mem_wr,    40'h80,   e_mem_size_64, {64{8'hA5}}, '0};
        vecs[1]  = '{0, e_cce_mem_rd,    40'h80,   e_mem_size_64, '0, {64{8'hA5}}};
        vecs[2]  = '{0, e_cce_mem_uc_wr, 40'h104,  e_mem_size_4,  {480'h0, 32'hDEADBEEF}, '0};
        vecs[3]  = '{0, e_cce_mem_uc_rd, 40'h104,  e_mem_size_4,  '0, {480'h0, 32'hDEADBEEF}};
        vecs[4]  = '{0, e_cce_mem_rd,    40'h100,  e_mem_size_64, '0, {448'h0, 32'hDEADBEEF, 32'h0}};
        vecs[5]  = '{0, e_cce_mem_uc_rd, 40'h106,  e_mem_size_2,  '0, {496'h0, 16'hDEAD}};
        vecs[6]  = '{0, e_cce_mem_uc_rd, 40'h107,  e_mem_size_2,  '0, {496'h0, 16'hDEAD}};
        vecs[7]  = '{0, e_cce_mem_wr,    40'h0,    e_mem_size_64, {16{32'h0BADF00D}}, '0};
        vecs[8]  = '{0, e_cce_mem_rd,    40'h4000, e_mem_size_64, '0, {16{32'h0BADF00D}}};
        vecs[9]  = '{0, bp_cce_mem_cmd_type_e'(4'd7), 40'h80, e_mem_size_64, {64{8'hFF}}, '0};
        vecs[10] = '{0, e_cce_mem_rd,    40'h80,   e_mem_size_64, '0, {64{8'hA5}}};
        vecs[11] = '{0, e_cce_mem_uc_wr, 40'h13E,  e_mem_size_8,  {448'h0, 64'h1122334455667788}, '0};
        vecs[12] = '{0, e_cce_mem_rd,    40'h100,  e_mem_size_64, '0,
                     {64'h1122334455667788, 384'h0, 32'hDEADBEEF, 32'h0}};
        vecs[13] = '{1, e_cce_mem_wr,    40'h40,   e_mem_size_64, {8{64'h0123456789ABCDEF}}, '0};
        vecs[14] = '{1, e_cce_mem_rd,    40'h40,   e_mem_size_64, '0, {8{64'h0123456789ABCDEF}}};
        vecs[15] = '{1, e_cce_mem_rd,    40'h4040, e_mem_size_64, '0, {8{64'h0123456789ABCDEF}}};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 640'(ready[d]), 640'(0));
            chk("reset_valid", 640'(resp_v[d]), 640'(0));
            chk("reset_resp", 640'(resp[d]), 640'(0));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk("ready_after_reset", 640'(ready[d]), 640'(1));

        foreach (vecs[i]) begin
            send(vecs[i].d, mk(vecs[i].t, vecs[i].addr, vecs[i].sz, vecs[i].data), vecs[i].exp, ok);
            if (ok) wait_resp(vecs[i].d, (vecs[i].d == 0) ? 5 : 1, 0, 1'b0);
        end

        // Backpressure: 10 cycles without yumi while a competing write is presented.
        send(0, mk(e_cce_mem_rd, 40'h80, e_mem_size_64, '0), {64{8'hA5}}, ok);
        if (ok) wait_resp(0, 5, 10, 1'b1);
        send(0, mk(e_cce_mem_rd, 40'h80, e_mem_size_64, '0), {64{8'hA5}}, ok);
        if (ok) wait_resp(0, 5, 0, 1'b0);

        // Reset while the response is being presented.
        send(0, mk(e_cce_mem_rd, 40'h100, e_mem_size_64, '0),
             {64'h1122334455667788, 384'h0, 32'hDEADBEEF, 32'h0}, ok);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = resp_v[0];
        end
        e = sb.pop_front();
        chk("resp_before_reset", 640'(resp[0]), 640'(e));
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid_drop_resp", 640'(resp_v[0]), 640'(0));
        chk("ready_in_reset", 640'(ready[0]), 640'(0));
        @(negedge clk);
        reset = 1'b0;

        // Reset while waiting, two cycles after acceptance.
        send(0, mk(e_cce_mem_wr, 40'h200, e_mem_size_64, {16{32'hCAFEF00D}}), '0, ok);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid_wait", 640'(resp_v[0]), 640'(0));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_mid_reset", 640'(ready[0]), 640'(1));

        send(0, mk(e_cce_mem_rd, 40'h200, e_mem_size_64, '0), '0, ok);
        if (ok) wait_resp(0, 5, 0, 1'b0);
        send(0, mk(e_cce_mem_rd, 40'h80, e_mem_size_64, '0), '0, ok);
        if (ok) wait_resp(0, 5, 0, 1'b0);
        send(1, mk(e_cce_mem_rd, 40'h40, e_mem_size_64, '0), '0, ok);
        if (ok) wait_resp(1, 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
